uart_tx_scheduler: RTL and testbench
====================================

// Module: uart_tx_scheduler
// PURPOSE
//   Shares one UART transmit path among NUM_REQ requesters using round-robin arbitration.
//   Sequences the uart_clk_divN baud divider: drives transmission_state and consumes its clk_out as baud_clk.
//   Serialises one 8N1-style frame per grant onto tx.
//   Sits between the on-chip message sources and the UART pin.
// PARAMETERS
//   NUM_REQ    4  number of requesters (>=2)
//   DATA_W     8  data bits per frame, sent LSB first
//   STOP_BITS  1  stop bits per frame (1 or 2)
//   GAP_CYCLES 16 clk_in cycles of idle-high tx after each frame; 0 = no gap
// PORTS
//   clk_in             in  1               system clock (50 MHz)
//   rst                in  1               synchronous reset, active-high
//   req                in  NUM_REQ         request per requester; held high until granted
//   data               in  NUM_REQ*DATA_W  payload; requester i at [i*DATA_W +: DATA_W]
//   grant              out NUM_REQ         one-hot pulse, 1 cycle; data captured on this edge
//   cur_id             out $clog2(NUM_REQ) index of requester whose frame is in progress
//   busy               out 1               high from grant until GAP completes
//   done               out 1               1-cycle pulse when the final stop bit ends
//   transmission_state out 1               enable to uart_clk_divN; high for the frame only
//   baud_clk           in  1               uart_clk_divN clk_out
//   tx                 out 1               serial line; idle high
// BEHAVIOUR
//   Reset (sync, dominates all other inputs): next edge gives tx=1, transmission_state=0, grant=0,
//     busy=0, done=0, cur_id=0, state=IDLE, baud_q=0, rr_ptr=NUM_REQ-1. Abort mid-frame is legal;
//     the partial frame is dropped.
//   Baud edge: baud_q registers baud_clk; bedge = baud_clk & ~baud_q & transmission_state.
//     bedge is ignored outside START/DATA/STOP. First rising edge arrives one bit period after
//     transmission_state rises.
//   Arbitration (IDLE only): search req from rr_ptr+1 upward, wrapping. First set bit wins.
//     On the next edge: grant[w]=1 for 1 cycle, shreg<=data[w], cur_id<=w, rr_ptr<=w, busy=1,
//     tx=0, transmission_state=1, state=START. Latency req->grant is 1 clk.
//   req is only sampled in IDLE; requests during a frame wait. Requester deasserts req after grant.
//     If req drops before grant, no frame is sent.
//   FSM:
//     START: tx=0. On bedge -> DATA, bit_idx=0, tx=shreg[0].
//     DATA: on bedge, if bit_idx==DATA_W-1 -> STOP, tx=1, stop_cnt=0; else shift right, bit_idx++.
//     STOP: tx=1. On bedge, if stop_cnt==STOP_BITS-1: transmission_state=0, done=1 (1 cycle),
//       then GAP (or IDLE if GAP_CYCLES=0, with busy=0); else stop_cnt++.
//     GAP: tx=1. Count GAP_CYCLES clk_in cycles, then IDLE with busy=0.
//       A new grant is possible on the first IDLE cycle.
//   Frame = 1+DATA_W+STOP_BITS baud edges. Default: 10 bits = 1.042 ms at 9600 baud.
//   Only one requester is ever active; grant is never multi-hot; tx never glitches low outside START/DATA.
// TESTING
//   T1 reset: rst=1 for 2 clk, random req/baud_clk -> tx=1, transmission_state=0, grant=0, busy=0, done=0.
//   T2 single frame: req=0001, data0=0x55 -> grant=0001 1 clk later.
//     tx bit sequence 0,1,0,1,0,1,0,1,0,1 across 10 bedges; done pulse; transmission_state low after the stop bit.
//   T3 round robin: req=1111 held, data_i=0xA0+i -> grants 0,1,2,3,0 in order; cur_id matches; payloads correct.
//   T4 contention: req1 rises during frame of req0 -> no grant until GAP ends (16 clk after done), then grant=0010.
//   T5 reset mid-frame at data bit 4 -> tx=1, transmission_state=0 next clk.
//     After release, req=0100 -> grant=0100, full clean frame.
//   T6 spurious edges: toggle baud_clk in IDLE/GAP -> no state change.
//     baud_clk high when enable rises -> no bedge until the next genuine rising edge.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler that shares one UART transmit path among NUM_REQ sources.
// Drives the baud divider enable, consumes its clock and serialises one frame per grant.
`timescale 1ns/1ps

module uart_tx_scheduler #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned GAP_CYCLES = 16
) (
    input  logic                         clk_in,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*DATA_W-1:0]    data,
    output logic [NUM_REQ-1:0]           grant,
    output logic [$clog2(NUM_REQ)-1:0]   cur_id,
    output logic                         busy,
    output logic                         done,
    output logic                         transmission_state,
    input  logic                         baud_clk,
    output logic                         tx
);

    localparam int unsigned ID_W   = $clog2(NUM_REQ);
    localparam int unsigned CAND_W = ID_W + 1;
    localparam int unsigned BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int unsigned STOP_W = 2;
    localparam int unsigned GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        GAP   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   shreg, shreg_d;
    logic [BIT_W-1:0]    bit_idx, bit_idx_d;
    logic [STOP_W-1:0]   stop_cnt, stop_cnt_d;
    logic [GAP_W-1:0]    gap_cnt, gap_cnt_d;
    logic [ID_W-1:0]     rr_ptr, rr_ptr_d;
    logic [ID_W-1:0]     cur_id_d;
    logic [NUM_REQ-1:0]  grant_d;
    logic                tx_d, ts_d, busy_d, done_d;
    logic                baud_q;
    logic                bedge_c;
    logic                found_c;
    logic [ID_W-1:0]     win_c;
    logic [CAND_W-1:0]   cand_c;

    // Rising edge of the divider output, only meaningful while the divider is enabled
    assign bedge_c = baud_clk & ~baud_q & transmission_state;

    // Round-robin search starting just after the last winner, wrapping around
    always_comb begin : arb_comb
        found_c = 1'b0;
        win_c   = '0;
        cand_c  = '0;
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            cand_c = {1'b0, rr_ptr} + CAND_W'(k);
            if (cand_c >= CAND_W'(NUM_REQ)) begin
                cand_c = cand_c - CAND_W'(NUM_REQ);
            end
            if (!found_c && req[cand_c[ID_W-1:0]]) begin
                found_c = 1'b1;
                win_c   = cand_c[ID_W-1:0];
            end
        end
    end

    // Next-state and next-output logic
    always_comb begin : fsm_comb
        state_d    = state_q;
        shreg_d    = shreg;
        bit_idx_d  = bit_idx;
        stop_cnt_d = stop_cnt;
        gap_cnt_d  = gap_cnt;
        rr_ptr_d   = rr_ptr;
        cur_id_d   = cur_id;
        grant_d    = '0;
        done_d     = 1'b0;
        tx_d       = tx;
        ts_d       = transmission_state;
        busy_d     = busy;

        case (state_q)
            IDLE: begin
                if (found_c) begin
                    grant_d  = NUM_REQ'(1) << win_c;
                    shreg_d  = data[win_c*DATA_W +: DATA_W];
                    cur_id_d = win_c;
                    rr_ptr_d = win_c;
                    busy_d   = 1'b1;
                    tx_d     = 1'b0;
                    ts_d     = 1'b1;
                    state_d  = START;
                end
            end
            START: begin
                if (bedge_c) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                    tx_d      = shreg[0];
                end
            end
            DATA: begin
                if (bedge_c) begin
                    if (bit_idx == BIT_W'(DATA_W - 1)) begin
                        state_d    = STOP;
                        tx_d       = 1'b1;
                        stop_cnt_d = '0;
                    end else begin
                        shreg_d   = shreg >> 1;
                        bit_idx_d = bit_idx + BIT_W'(1);
                        tx_d      = shreg_d[0];
                    end
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (bedge_c) begin
                    if (stop_cnt == STOP_W'(STOP_BITS - 1)) begin
                        ts_d   = 1'b0;
                        done_d = 1'b1;
                        if (GAP_CYCLES == 0) begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                        end else begin
                            state_d   = GAP;
                            gap_cnt_d = '0;
                        end
                    end else begin
                        stop_cnt_d = stop_cnt + STOP_W'(1);
                    end
                end
            end
            GAP: begin
                tx_d = 1'b1;
                if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    gap_cnt_d = gap_cnt + GAP_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                ts_d    = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any frame in flight
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q            <= IDLE;
            shreg              <= '0;
            bit_idx            <= '0;
            stop_cnt           <= '0;
            gap_cnt            <= '0;
            rr_ptr             <= ID_W'(NUM_REQ - 1);
            cur_id             <= '0;
            grant              <= '0;
            done               <= 1'b0;
            tx                 <= 1'b1;
            transmission_state <= 1'b0;
            busy               <= 1'b0;
            baud_q             <= 1'b0;
        end else begin
            state_q            <= state_d;
            shreg              <= shreg_d;
            bit_idx            <= bit_idx_d;
            stop_cnt           <= stop_cnt_d;
            gap_cnt            <= gap_cnt_d;
            rr_ptr             <= rr_ptr_d;
            cur_id             <= cur_id_d;
            grant              <= grant_d;
            done               <= done_d;
            tx                 <= tx_d;
            transmission_state <= ts_d;
            busy               <= busy_d;
            baud_q             <= baud_clk;
        end
    end

    // Structural invariants of the line and the arbiter
    a_grant_onehot: assert property (@(posedge clk_in) $onehot0(grant));
    a_tx_idle_high: assert property (@(posedge clk_in) disable iff (rst)
                                     (state_q != START && state_q != DATA) |-> tx);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: arbitration table, multi-cycle corner sequences and
// randomized traffic checked against a queue-free round-robin/frame model.
`timescale 1ns/1ps

module tb_uart_tx_scheduler;

    localparam int unsigned NUM_REQ    = 4;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned STOP_BITS  = 1;
    localparam int unsigned GAP_CYCLES = 16;
    localparam int unsigned ID_W       = $clog2(NUM_REQ);
    localparam int          HALF       = 3;
    localparam int          FRAME_LEN  = 1 + DATA_W + STOP_BITS;

    logic                       clk_in = 1'b0;
    logic                       rst;
    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ*DATA_W-1:0]  data;
    logic [NUM_REQ-1:0]         grant;
    logic [ID_W-1:0]            cur_id;
    logic                       busy, done, transmission_state, baud_clk, tx;

    uart_tx_scheduler #(
        .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .STOP_BITS(STOP_BITS), .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .clk_in(clk_in), .rst(rst), .req(req), .data(data), .grant(grant), .cur_id(cur_id),
        .busy(busy), .done(done), .transmission_state(transmission_state),
        .baud_clk(baud_clk), .tx(tx)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_fail   = 0;
    int frame_bad;

    typedef struct {
        logic [NUM_REQ-1:0] req;
        logic [DATA_W-1:0]  payload;
        int                 exp_id;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
        end
    endtask

    function automatic int rr_pick(input logic [NUM_REQ-1:0] m, input int last);
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            int i;
            i = (last + k) % int'(NUM_REQ);
            if (m[i]) return i;
        end
        return -1;
    endfunction

    task automatic randomize_data();
        for (int i = 0; i < int'(NUM_REQ); i++) data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
    endtask

    task automatic wait_grant(output int n, output logic [NUM_REQ-1:0] g);
        n = 0;
        g = '0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk_in);
            if (grant != '0) begin
                n = c;
                g = grant;
                break;
            end
        end
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while (busy && c < 200) begin
            @(negedge clk_in);
            c++;
        end
        check("idle_reached", 32'(busy), 32'(0));
    endtask

    // Mid-frame line must hold its bit, keep enable/busy up, and show no done/grant
    task automatic watch(input int cyc, input logic cur);
        repeat (cyc) begin
            @(negedge clk_in);
            if (tx !== cur || done || !busy || !transmission_state || grant != '0) frame_bad++;
        end
    endtask

    task automatic baud_pulse();
        baud_clk = 1'b0;
        repeat (HALF) @(negedge clk_in);
        baud_clk = 1'b1;
        @(negedge clk_in);
        repeat (HALF - 1) @(negedge clk_in);
    endtask

    // Acts as the baud divider and as a line receiver for one frame; entered on the grant cycle
    task automatic run_frame(input logic [DATA_W-1:0] exp_b, input int exp_id, input bit hold_high);
        logic [DATA_W-1:0]    got_data;
        logic [STOP_BITS-1:0] got_stop;
        logic [STOP_BITS-1:0] ones;
        logic                 cur, end_done, end_ts, end_tx;
        got_data  = '0;
        got_stop  = '0;
        ones      = '1;
        end_done  = 1'b0;
        end_ts    = 1'b1;
        end_tx    = 1'b0;
        frame_bad = 0;
        check("start_bit", 32'(tx), 32'(0));
        check("enable_on", 32'(transmission_state), 32'(1));
        check("cur_id", 32'(cur_id), 32'(exp_id));
        cur = tx;
        for (int j = 1; j <= FRAME_LEN; j++) begin
            if (j == 1 && hold_high) begin
                baud_clk = 1'b1;
                watch(2 * HALF, cur);
            end
            baud_clk = 1'b0;
            watch(HALF, cur);
            baud_clk = 1'b1;
            @(negedge clk_in);
            if (j < FRAME_LEN) begin
                cur = tx;
                if (j <= int'(DATA_W)) got_data[j-1] = tx;
                else                   got_stop[j-int'(DATA_W)-1] = tx;
                if (done || !busy || !transmission_state || grant != '0) frame_bad++;
                watch(HALF - 1, cur);
            end else begin
                end_done = done;
                end_ts   = transmission_state;
                end_tx   = tx;
            end
        end
        baud_clk = 1'b0;
        @(negedge clk_in);
        check("data_bits", 32'(got_data), 32'(exp_b));
        check("stop_bits", 32'(got_stop), 32'(ones));
        check("frame_steady", 32'(frame_bad), 32'(0));
        check("done_pulse", 32'(end_done), 32'(1));
        check("enable_off", 32'(end_ts), 32'(0));
        check("line_idle_after", 32'(end_tx), 32'(1));
        check("done_one_cycle", 32'(done), 32'(0));
    endtask

    task automatic reset_dut();
        req      = '0;
        baud_clk = 1'b0;
        rst      = 1'b1;
        @(negedge clk_in);
        rst      = 1'b0;
    endtask

    initial begin
        vec_t                      tbl [9];
        int                        n, seen, ptr, pick, exp_wait;
        logic [NUM_REQ-1:0]        g, pend;
        logic [NUM_REQ*DATA_W-1:0] snap;
        logic [DATA_W-1:0]         exp_b;
        int                        order [5];

        tbl[0] = '{4'b0001, 8'h55, 0};
        tbl[1] = '{4'b1111, 8'h3C, 1};
        tbl[2] = '{4'b1101, 8'hC3, 2};
        tbl[3] = '{4'b0011, 8'h0F, 0};
        tbl[4] = '{4'b0000, 8'h00, -1};
        tbl[5] = '{4'b1000, 8'hF0, 3};
        tbl[6] = '{4'b0110, 8'h96, 1};
        tbl[7] = '{4'b0101, 8'h69, 2};
        tbl[8] = '{4'b1011, 8'hA5, 3};
        order  = '{0, 1, 2, 3, 0};

        // Reset dominates random request/baud activity
        rst      = 1'b1;
        req      = NUM_REQ'($urandom);
        baud_clk = 1'($urandom);
        randomize_data();
        repeat (2) begin
            @(negedge clk_in);
            req      = NUM_REQ'($urandom);
            baud_clk = 1'($urandom);
        end
        check("rst_tx", 32'(tx), 32'(1));
        check("rst_enable", 32'(transmission_state), 32'(0));
        check("rst_grant", 32'(grant), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_cur_id", 32'(cur_id), 32'(0));
        req      = '0;
        baud_clk = 1'b0;
        rst      = 1'b0;

        // Arbitration table: each request set applied from idle, single-cycle latency
        for (int v = 0; v < 9; v++) begin
            wait_idle();
            for (int i = 0; i < int'(NUM_REQ); i++)
                data[i*DATA_W +: DATA_W] = tbl[v].payload + 8'(i * 17);
            req = tbl[v].req;
            if (tbl[v].exp_id < 0) begin
                seen = 0;
                repeat (5) begin
                    @(negedge clk_in);
                    if (grant != '0 || busy) seen++;
                end
                check("no_req_no_grant", 32'(seen), 32'(0));
                req = '0;
            end else begin
                @(negedge clk_in);
                check("tbl_grant", 32'(grant), 32'(1) << tbl[v].exp_id);
                exp_b = tbl[v].payload + 8'(tbl[v].exp_id * 17);
                req   = '0;
                randomize_data();
                run_frame(exp_b, tbl[v].exp_id, 1'b0);
            end
        end
        wait_idle();

        // All requesters held: strict rotation, next grant one gap after done
        reset_dut();
        for (int i = 0; i < int'(NUM_REQ); i++) data[i*DATA_W +: DATA_W] = 8'hA0 + 8'(i);
        req = '1;
        for (int k = 0; k < 5; k++) begin
            wait_grant(n, g);
            check("rr_grant", 32'(g), 32'(1) << order[k]);
            check("rr_latency", 32'(n), (k == 0) ? 32'(1) : 32'(GAP_CYCLES));
            run_frame(8'hA0 + 8'(order[k]), order[k], 1'b0);
        end
        req = '0;
        wait_idle();

        // Contention: requester 1 arrives mid-frame and waits out the gap
        req = 4'b0001;
        data[0 +: DATA_W]      = 8'h3A;
        data[DATA_W +: DATA_W] = 8'hC5;
        wait_grant(n, g);
        check("cont_first_grant", 32'(g), 32'(4'b0001));
        req = 4'b0010;
        run_frame(8'h3A, 0, 1'b0);
        wait_grant(n, g);
        check("cont_wait", 32'(n), 32'(GAP_CYCLES));
        check("cont_second_grant", 32'(g), 32'(4'b0010));
        req = '0;
        run_frame(8'hC5, 1, 1'b0);
        wait_idle();

        // Reset at data bit 4 drops the frame; a clean frame follows
        req = 4'b0010;
        data[DATA_W +: DATA_W] = 8'hEF;
        wait_grant(n, g);
        check("abort_grant", 32'(g), 32'(4'b0010));
        req = '0;
        repeat (5) baud_pulse();
        check("abort_bit4", 32'(tx), 32'(0));
        rst = 1'b1;
        @(negedge clk_in);
        check("abort_state", 32'({tx, transmission_state, busy, done, grant}), 32'(8'b1000_0000));
        check("abort_cur_id", 32'(cur_id), 32'(0));
        rst      = 1'b0;
        baud_clk = 1'b0;
        req      = 4'b0100;
        data[2*DATA_W +: DATA_W] = 8'hB4;
        wait_grant(n, g);
        check("post_abort_latency", 32'(n), 32'(1));
        check("post_abort_grant", 32'(g), 32'(4'b0100));
        req = '0;
        run_frame(8'hB4, 2, 1'b0);
        wait_idle();

        // Baud activity outside a frame, and baud already high when the enable rises
        seen = 0;
        repeat (10) begin
            baud_clk = ~baud_clk;
            @(negedge clk_in);
            if (tx !== 1'b1 || transmission_state || busy || done || grant != '0) seen++;
        end
        check("idle_spurious", 32'(seen), 32'(0));
        baud_clk = 1'b1;
        @(negedge clk_in);
        req = 4'b0001;
        data[0 +: DATA_W] = 8'h81;
        wait_grant(n, g);
        check("high_baud_grant", 32'(g), 32'(4'b0001));
        req = '0;
        run_frame(8'h81, 0, 1'b1);
        seen = 0;
        repeat (GAP_CYCLES - 4) begin
            baud_clk = ~baud_clk;
            @(negedge clk_in);
            if (tx !== 1'b1 || transmission_state || done || !busy || grant != '0) seen++;
        end
        check("gap_spurious", 32'(seen), 32'(0));
        baud_clk = 1'b0;
        wait_idle();

        // Randomized traffic against the round-robin model
        reset_dut();
        ptr  = int'(NUM_REQ) - 1;
        pend = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
        req  = pend;
        randomize_data();
        exp_wait = 1;
        for (int it = 0; it < 20; it++) begin
            snap = data;
            pick = rr_pick(pend, ptr);
            wait_grant(n, g);
            check("rnd_latency", 32'(n), 32'(exp_wait));
            check("rnd_grant", 32'(g), 32'(1) << pick);
            ptr  = pick;
            pend[pick] = 1'b0;
            req  = pend;
            randomize_data();
            run_frame(snap[pick*DATA_W +: DATA_W], pick, 1'b0);
            pend = pend | NUM_REQ'($urandom_range(0, (1 << NUM_REQ) - 1));
            if ($urandom_range(0, 3) == 0) pend[$urandom_range(0, NUM_REQ - 1)] = 1'b0;
            if ($urandom_range(0, 4) == 0) pend = '0;
            req = pend;
            randomize_data();
            if (pend == '0) begin
                repeat (GAP_CYCLES - 2) @(negedge clk_in);
                check("rnd_busy_in_gap", 32'(busy), 32'(1));
                @(negedge clk_in);
                check("rnd_busy_drop", 32'(busy), 32'(0));
                seen = 0;
                repeat (3) begin
                    @(negedge clk_in);
                    if (grant != '0 || busy) seen++;
                end
                check("rnd_quiet_idle", 32'(seen), 32'(0));
                pend = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
                req  = pend;
                randomize_data();
                exp_wait = 1;
            end else begin
                exp_wait = int'(GAP_CYCLES);
            end
        end
        req = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
